// File: rtl/cacheline_burst_adaptor.sv
// Cacheline <-> memory burst adaptor: splits a 256-bit line into 64-bit beats
// for write-back and reassembles beats into a line for fills.
module cacheline_burst_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int OFFS  = $clog2(LINE_W / 8);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFFS) - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [LINE_W-1:0]  r_wbuf;
    logic [LINE_W-1:0]  r_line;
    logic               w_last;

    assign w_last = resp_i && (r_cnt == CNT_W'(BEATS - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                // write wins when both are raised together
                if (write_i)     w_next = WR_BURST;
                else if (read_i) w_next = RD_BURST;
            end
            RD_BURST, WR_BURST: if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wbuf  <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (write_i || read_i) r_addr <= address_i & ALIGN_MASK;
                    if (write_i)           r_wbuf <= line_i;
                end
                RD_BURST: begin
                    if (resp_i) begin
                        r_line[BURST_W*r_cnt +: BURST_W] <= burst_i;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WR_BURST: begin
                    if (resp_i) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign read_o    = (r_state == RD_BURST);
    assign write_o   = (r_state == WR_BURST);
    assign resp_o    = (r_state == DONE);
    assign line_o    = r_line;
    assign address_o = (read_o || write_o) ? r_addr : '0;
    assign burst_o   = write_o ? r_wbuf[BURST_W*r_cnt +: BURST_W] : '0;
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench for cacheline_burst_adaptor: read/write bursts, gapped
// beats, back-to-back transfers, request priority and mid-burst reset.
module tb_cacheline_burst_adaptor;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0, write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o, write_o;
    logic         resp_i = 1'b0;

    int n_chk = 0, n_pass = 0;
    logic [255:0] q_line[$];
    logic [63:0]  q_beat[$];

    cacheline_burst_adaptor dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Drives one full burst; pat[i] is resp_i in the i-th beat-phase cycle.
    task automatic run_burst(input bit wr, input bit both, input logic [31:0] addr,
                             input logic [255:0] line, input logic [15:0] pat);
        int beat = 0;
        int cyc = 0;
        logic [63:0] exp;
        address_i = addr;
        if (wr) begin
            write_i = 1'b1;
            read_i  = both;
            line_i  = line;
            for (int i = 0; i < 4; i++) q_beat.push_back(line[64*i +: 64]);
        end else begin
            read_i = 1'b1;
            q_line.push_back(line);
        end
        step();
        read_i = 1'b0; write_i = 1'b0;
        line_i = {4{64'hDEAD_BEEF_0BAD_F00D}};
        address_i = 32'hFFFF_FFFF;
        chk(wr ? "write_o_rise" : "read_o_rise", wr ? write_o : read_o, 1'b1);
        chk("other_req_low", wr ? read_o : write_o, 1'b0);
        chk("address_o", address_o, {addr[31:5], 5'b0});
        while (beat < 4 && cyc < 64) begin
            resp_i = pat[cyc % 16];
            chk("no_early_resp", resp_o, 1'b0);
            if (wr) begin
                exp = q_beat[0];
                chk("burst_o", burst_o, exp);
                if (resp_i) void'(q_beat.pop_front());
            end
            if (resp_i) begin
                burst_i = wr ? 64'h0 : line[64*beat +: 64];
                beat++;
            end else begin
                burst_i = {$urandom, $urandom};
            end
            step();
            cyc++;
        end
        resp_i = 1'b0; burst_i = '0;
        chk("beats_done", 32'(beat), 32'd4);
        chk("resp_o_pulse", resp_o, 1'b1);
        chk("req_dropped", {read_o, write_o}, 2'b00);
        if (!wr) chk("line_o", line_o, q_line.pop_front());
        step();
        chk("resp_o_single", resp_o, 1'b0);
    endtask

    logic [255:0] la, lb, lc, ld;

    initial begin
        la = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
              64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        lb = {64'hD1D1_D1D1_D1D1_D1D1, 64'hC2C2_C2C2_C2C2_C2C2,
              64'hB3B3_B3B3_B3B3_B3B3, 64'hA4A4_A4A4_A4A4_A4A4};
        lc = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        ld = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

        #12;
        chk("rst_outs", {line_o, burst_o, address_o, read_o, write_o, resp_o}, '0);
        rst = 1'b1;
        step();
        // resp_i in IDLE must not start anything
        resp_i = 1'b1; step(); resp_i = 1'b0;
        chk("idle_ignores_resp", {read_o, write_o, resp_o}, 3'b000);

        run_burst(1'b0, 1'b0, 32'h1234_567F, la, 16'hFFFF);   // ideal read
        run_burst(1'b1, 1'b0, 32'h0000_1008, lb, 16'hFFFF);   // ideal write
        chk("line_o_hold", line_o, la);
        run_burst(1'b0, 1'b0, 32'hABCD_0020, lc, 16'h0059);   // gapped read
        run_burst(1'b1, 1'b0, 32'h5555_5555, ld, 16'h0059);   // gapped write
        // write-back then immediate read-back, no idle cycle between
        run_burst(1'b1, 1'b0, 32'h8000_0040, lc, 16'hFFFF);
        run_burst(1'b0, 1'b0, 32'h8000_0080, ld, 16'hFFFF);
        // simultaneous request: write only
        run_burst(1'b1, 1'b1, 32'h0000_00E0, la, 16'hFFFF);

        // reset during beat 2 of a read
        address_i = 32'h2222_2200; read_i = 1'b1; step(); read_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_i = 1'b1; burst_i = lb[64*i +: 64]; step();
        end
        resp_i = 1'b1; burst_i = lb[128 +: 64];
        #2 rst = 1'b0; #1;
        chk("rst_mid_outs", {line_o, burst_o, address_o, read_o, write_o, resp_o}, '0);
        resp_i = 1'b0; burst_i = '0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_resp", {resp_o, read_o}, 2'b00);
        end
        run_burst(1'b0, 1'b0, 32'h3333_3300, lc, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
